alu_issue_arbiter: RTL and testbench

Shares the single ALU datapath (operand mux plus ALU) between two requesters, e.g. the main pipeline issue stage and the multi-cycle mul/branch-compare unit. Each cycle it picks at most one request using round-robin priority, then latches and drives the operands, the opcode and the ALU source select. It waits for the ALU to complete and returns the result over a response channel that supports backpressure. A watchdog terminates any operation that never completes.

---
 rtl/alu_issue_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters, issues the
// selected operation, waits for completion (with watchdog) and returns the result.
module alu_issue_arbiter #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int DATA_2_WIDTH   = 4,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [ALU_OP_WIDTH-1:0]   req0_op,
    input  logic [REG_DATA_WIDTH-1:0] req0_data_1,
    input  logic [DATA_2_WIDTH-1:0]   req0_data_2,
    input  logic                      req0_alu_src,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [ALU_OP_WIDTH-1:0]   req1_op,
    input  logic [REG_DATA_WIDTH-1:0] req1_data_1,
    input  logic [DATA_2_WIDTH-1:0]   req1_data_2,
    input  logic                      req1_alu_src,
    output logic                      alu_start,
    output logic [ALU_OP_WIDTH-1:0]   alu_op,
    output logic [REG_DATA_WIDTH-1:0] alu_data_1,
    output logic [DATA_2_WIDTH-1:0]   alu_data_2,
    output logic                      alu_src,
    input  logic                      alu_done,
    input  logic [REG_DATA_WIDTH-1:0] alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [REG_DATA_WIDTH-1:0] rsp_result,
    output logic                      rsp_err,
    output logic                      busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Watchdog fires on the TIMEOUT-th WAIT cycle, i.e. when the count of
    // already-elapsed WAIT cycles equals TIMEOUT-1.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_grant;
    logic [7:0] wd_cnt;
    logic       grant;
    logic       any_valid;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Requesters see ready only in IDLE; the response holds until rsp_ready.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else if (req1_valid)          grant = 1'b1;
        else                          grant = 1'b0;
    end

    assign req0_ready = (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready = (state == S_IDLE) && req1_valid && grant;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_data_1 <= '0;
            alu_data_2 <= '0;
            alu_src    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        alu_op     <= grant ? req1_op      : req0_op;
                        alu_data_1 <= grant ? req1_data_1  : req0_data_1;
                        alu_data_2 <= grant ? req1_data_2  : req0_data_2;
                        alu_src    <= grant ? req1_alu_src : req0_alu_src;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        alu_start  <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: issue timing, round-robin, backpressure,
// watchdog, asynchronous reset and spurious alu_done.
module tb_alu_issue_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_data_1, req1_data_1;
    logic [3:0]  req0_data_2, req1_data_2;
    logic        req0_alu_src, req1_alu_src;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [15:0] alu_data_1;
    logic [3:0]  alu_data_2;
    logic        alu_src;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [15:0] rsp_result;

    logic        auto_en   = 1'b0;
    logic        auto_done = 1'b0;
    logic        pending   = 1'b0;
    logic        man_done  = 1'b0;
    logic [15:0] alu_res   = 16'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(
        .REG_DATA_WIDTH(16), .DATA_2_WIDTH(4), .ALU_OP_WIDTH(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data_1(req0_data_1), .req0_data_2(req0_data_2), .req0_alu_src(req0_alu_src),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data_1(req1_data_1), .req1_data_2(req1_data_2), .req1_alu_src(req1_alu_src),
        .alu_start(alu_start), .alu_op(alu_op), .alu_data_1(alu_data_1),
        .alu_data_2(alu_data_2), .alu_src(alu_src), .alu_done(alu_done),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    // ALU model: done one cycle after the start pulse when auto_en is set.
    assign alu_done   = auto_done | man_done;
    assign alu_result = alu_res;
    always begin
        @(posedge clk);
        #1;
        auto_done = pending;
        pending   = auto_en && alu_start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_op = 0; req0_data_1 = 0; req0_data_2 = 0; req0_alu_src = 0;
        req1_valid = 0; req1_op = 0; req1_data_1 = 0; req1_data_2 = 0; req1_alu_src = 0;
        rsp_ready = 0; man_done = 0;
    endtask

    task automatic drive_req(input int n, input logic [3:0] op, input logic [15:0] d1,
                             input logic [3:0] d2, input logic src);
        if (n == 0) begin
            req0_op = op; req0_data_1 = d1; req0_data_2 = d2; req0_alu_src = src; req0_valid = 1;
        end else begin
            req1_op = op; req1_data_1 = d1; req1_data_2 = d2; req1_alu_src = src; req1_valid = 1;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        settle();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_alu_start", 32'(alu_start), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_result", 32'(rsp_result), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h0);
        tick();
        rst = 0;

        // 1: single immediate operation
        auto_en = 1; alu_res = 16'h0004; rsp_ready = 1;
        drive_req(0, 4'h1, 16'h0005, 4'hF, 1'b1);
        settle();
        check("t1_ready0", 32'(req0_ready), 32'h1);
        check("t1_ready1", 32'(req1_ready), 32'h0);
        tick();
        req0_valid = 0;
        settle();
        check("t1_start", 32'(alu_start), 32'h1);
        check("t1_src", 32'(alu_src), 32'h1);
        check("t1_data2", 32'(alu_data_2), 32'hF);
        check("t1_op", 32'(alu_op), 32'h1);
        check("t1_data1", 32'(alu_data_1), 32'h5);
        check("t1_busy_ready0", 32'(req0_ready), 32'h0);
        tick(); settle();
        check("t1_start_pulse", 32'(alu_start), 32'h0);
        check("t1_rsp_early", 32'(rsp_valid), 32'h0);
        tick(); settle();
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_id", 32'(rsp_id), 32'h0);
        check("t1_rsp_result", 32'(rsp_result), 32'h4);
        check("t1_rsp_err", 32'(rsp_err), 32'h0);
        tick(); settle();
        check("t1_rsp_drop", 32'(rsp_valid), 32'h0);
        check("t1_idle", 32'(busy), 32'h0);

        // 2: round-robin with both requesters always valid
        do_reset();
        auto_en = 1; rsp_ready = 1; alu_res = 16'h0011;
        drive_req(0, 4'h2, 16'h0100, 4'h1, 1'b0);
        drive_req(1, 4'h3, 16'h0200, 4'h2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = k[0];
            settle();
            check("t2_grant0", 32'(req0_ready), 32'(!g));
            check("t2_grant1", 32'(req1_ready), 32'(g));
            tick(); settle();
            check("t2_issue_op", 32'(alu_op), g ? 32'h3 : 32'h2);
            check("t2_busy_rdy", 32'({busy, req0_ready, req1_ready}), 32'h4);
            tick(); settle();
            check("t2_busy_rdy", 32'({busy, req0_ready, req1_ready}), 32'h4);
            tick(); settle();
            check("t2_busy_rdy", 32'({busy, req0_ready, req1_ready}), 32'h4);
            check("t2_rsp_id", 32'(rsp_id), 32'(g));
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // 3: response backpressure with req1 waiting
        do_reset();
        auto_en = 1; alu_res = 16'hA5A5; rsp_ready = 0;
        drive_req(0, 4'h4, 16'h0001, 4'h0, 1'b0);
        drive_req(1, 4'h5, 16'h0002, 4'h0, 1'b0);
        settle();
        check("t3_ready0", 32'(req0_ready), 32'h1);
        tick();
        req0_valid = 0;
        tick(); tick(); settle();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(rsp_valid), 32'h1);
            check("t3_hold_id", 32'(rsp_id), 32'h0);
            check("t3_hold_result", 32'(rsp_result), 32'hA5A5);
            check("t3_ready1_low", 32'(req1_ready), 32'h0);
            tick(); settle();
        end
        rsp_ready = 1;
        settle();
        check("t3_still_valid", 32'(rsp_valid), 32'h1);
        tick(); settle();
        check("t3_idle", 32'(busy), 32'h0);
        check("t3_rsp_drop", 32'(rsp_valid), 32'h0);
        check("t3_ready1", 32'(req1_ready), 32'h1);
        req1_valid = 0;

        // 4a: watchdog, no alu_done at all
        do_reset();
        auto_en = 0; alu_res = 16'hFFFF; rsp_ready = 1;
        drive_req(0, 4'h6, 16'h0003, 4'h0, 1'b0);
        tick();
        req0_valid = 0;
        tick(); settle();
        for (int w = 1; w <= 8; w++) begin
            check("t4_wait_no_rsp", 32'(rsp_valid), 32'h0);
            check("t4_wait_busy", 32'(busy), 32'h1);
            tick(); settle();
        end
        check("t4_to_valid", 32'(rsp_valid), 32'h1);
        check("t4_to_err", 32'(rsp_err), 32'h1);
        check("t4_to_result", 32'(rsp_result), 32'h0);
        tick(); settle();
        check("t4_to_idle", 32'(busy), 32'h0);

        // 4b: alu_done on the 8th WAIT cycle beats the timeout
        alu_res = 16'h1234;
        drive_req(0, 4'h7, 16'h0004, 4'h0, 1'b0);
        tick();
        req0_valid = 0;
        tick(); settle();
        for (int w = 1; w <= 7; w++) begin
            check("t4b_wait_no_rsp", 32'(rsp_valid), 32'h0);
            tick(); settle();
        end
        man_done = 1;
        tick();
        man_done = 0;
        settle();
        check("t4b_valid", 32'(rsp_valid), 32'h1);
        check("t4b_err", 32'(rsp_err), 32'h0);
        check("t4b_result", 32'(rsp_result), 32'h1234);
        tick(); settle();

        // 5: asynchronous reset in WAIT after a req0 grant
        drive_req(0, 4'h8, 16'h0005, 4'h0, 1'b0);
        tick();
        req0_valid = 0;
        tick(); settle();
        check("t5_in_wait", 32'(busy), 32'h1);
        rst = 1;
        settle();
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_start", 32'(alu_start), 32'h0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t5_rsp_result", 32'(rsp_result), 32'h0);
        check("t5_rsp_err", 32'(rsp_err), 32'h0);
        check("t5_alu_op", 32'(alu_op), 32'h0);
        tick();
        rst = 0;
        man_done = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            man_done = 0;
            check("t5_no_rsp", 32'(rsp_valid), 32'h0);
            check("t5_idle", 32'(busy), 32'h0);
        end
        drive_req(0, 4'h9, 16'h0006, 4'h0, 1'b0);
        drive_req(1, 4'hA, 16'h0007, 4'h0, 1'b0);
        settle();
        check("t5_tie_ready0", 32'(req0_ready), 32'h1);
        check("t5_tie_ready1", 32'(req1_ready), 32'h0);
        req0_valid = 0; req1_valid = 0;

        // 6: spurious alu_done in IDLE and in RESP
        tick();
        alu_res = 16'hBEEF; man_done = 1;
        tick();
        man_done = 0;
        settle();
        check("t6_idle_busy", 32'(busy), 32'h0);
        check("t6_idle_valid", 32'(rsp_valid), 32'h0);
        check("t6_idle_result", 32'(rsp_result), 32'h0);
        auto_en = 1; alu_res = 16'h0042; rsp_ready = 0;
        drive_req(1, 4'hB, 16'h0008, 4'h3, 1'b1);
        tick();
        req1_valid = 0;
        tick(); tick(); settle();
        check("t6_resp_result", 32'(rsp_result), 32'h0042);
        check("t6_resp_id", 32'(rsp_id), 32'h1);
        alu_res = 16'hDEAD; man_done = 1;
        tick();
        man_done = 0;
        settle();
        check("t6_resp_valid", 32'(rsp_valid), 32'h1);
        check("t6_resp_hold", 32'(rsp_result), 32'h0042);
        check("t6_resp_busy", 32'(busy), 32'h1);
        rsp_ready = 1;
        tick(); settle();
        check("t6_done_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
